bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Digit-serial multi-digit BCD adder controller. Accepts two packed `DIGITS`-digit BCD operands plus carry-in on a start strobe. It then steps them least-significant digit first through one internal `one_digit_BCD_adder` instance, one digit per clock, chaining the carry in a register. The block sits directly upstream of the one-digit adder, drives its `A`, `B` and `Cin` inputs, and collects its `S` and `C` outputs into a packed multi-digit result with a done pulse.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand, minimum 1.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request strobe, sampled only in IDLE.
- `a`, input, 4*DIGITS: operand A, packed BCD; digit i is in `a[4i+3:4i]`, digit 0 is least significant.
- `b`, input, 4*DIGITS: operand B, same packing as `a`.
- `cin`, input, 1: carry into digit 0.
- `busy`, output, 1: high while digits are being processed (RUN state).
- `done`, output, 1: one-cycle pulse when the result is valid.
- `sum`, output, 4*DIGITS: packed BCD result, registered.
- `cout`, output, 1: carry out of the most significant digit, registered.
- `err`, output, 1: high if any input digit exceeded 9 in the last request.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE with `start`=1:**
  - Capture `a`, `b` and `cin` into working registers.
  - Clear digit index and working sum.
  - Check every digit of `a` and `b`.
  - If any digit is above 9, go to DONE and update outputs: `err`=1, `sum`=0, `cout`=0. No digit is processed.
  - Otherwise go to RUN and clear `err`.
- **RUN, each clock:**
  - Feed digit[idx] of the captured A and B, plus the carry register, to the adder.
  - Write adder `S` into working-sum digit idx.
  - Load carry register with adder `C`.
  - Increment idx.
  - On the edge that processes digit `DIGITS-1`, copy the working sum and final carry to `sum`/`cout` and go to DONE.
- **DONE:** `done`=1 for exactly this one cycle, then return to IDLE unconditionally.
- `sum`, `cout` and `err` hold their values from DONE until the next accepted request completes. They never show partial results.
- `start` is ignored in RUN and DONE. There is no queueing.
- Input operands may change freely after the accepting edge.
- Arithmetic: result equals (A + B + cin) in decimal. Digits above 9 never appear in `sum`. `cout` is the decimal carry out of digit `DIGITS-1`.
- Index counter width is clog2(DIGITS), minimum 1 bit. The counter wraps only through the reset to 0 on accept.

## Timing
- Reset (`rst_n` low, asynchronous, effective immediately): state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `err`=0, carry register 0, idx 0.
- Reset asserted mid-RUN or in DONE aborts the operation. No `done` is produced, and outputs go to their reset values.
- Valid request accepted at edge k:
  - `busy` is high from edge k to edge k+DIGITS.
  - `done`, `sum` and `cout` update at edge k+DIGITS.
  - `done` falls at edge k+DIGITS+1.
  - The earliest next accept is edge k+DIGITS+2, one idle cycle between requests. `start` held high is accepted there.
- Invalid request accepted at edge k: `busy` never rises. `done`=1, `err`=1 and `sum`=0 from edge k to edge k+1.
- `busy` and `done` are never high together.
- Throughput: one `DIGITS`-digit add per DIGITS+2 cycles.

## Test plan
All scenarios use `DIGITS`=4.
1. Reset, then `a`=16'h1234, `b`=16'h5678, `cin`=0, `start` pulse at edge k -> `busy` high for 4 cycles; `done` at edge k+4; `sum`=16'h6912, `cout`=0, `err`=0.
2. `a`=16'h9999, `b`=16'h0001, `cin`=0 -> `sum`=16'h0000, `cout`=1 (ripple through all digits).
3. `a`=16'h9999, `b`=16'h9999, `cin`=1 -> `sum`=16'h9999, `cout`=1.
   - Then `a`=16'h0000, `b`=16'h0000, `cin`=0 -> `sum`=16'h0000, `cout`=0.
4. `a`=16'h12A4, `b`=16'h0001 -> `done` and `err`=1 at edge k, `busy` stays 0, `sum`=0, `cout`=0.
   - Next valid request 16'h0005+16'h0005 clears `err` and gives `sum`=16'h0010.
5. Start 16'h1111+16'h2222, then assert `rst_n` low two cycles after accept -> all outputs 0 immediately and no `done`.
   - After release, 16'h4444+16'h4444 -> `sum`=16'h8888.
6. Pulse `start` with different operands during RUN and again during DONE -> both ignored and the original result is reported. Holding `start` high continuously gives one accept every 6 cycles.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: walks two packed BCD operands LSD first
// through a single one-digit BCD adder, one digit per clock.
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  wsum;
   logic [W-1:0]  wsum_nx;
   logic          carry;
   logic [IW-1:0] idx;
   logic [3:0]    da;
   logic [3:0]    db;
   logic [3:0]    ds;
   logic          dc;
   logic          bad;
   logic          last;

   function automatic logic has_bad(input logic [W-1:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   always_comb begin
      da      = a_q[4*idx +: 4];
      db      = b_q[4*idx +: 4];
      last    = (idx == IW'(DIGITS - 1));
      bad     = has_bad(a) | has_bad(b);
      wsum_nx = wsum;
      wsum_nx[4*idx +: 4] = ds;
   end

   one_digit_BCD_adder u_digit (
      .A   (da),
      .B   (db),
      .Cin (carry),
      .S   (ds),
      .C   (dc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         wsum  <= '0;
         carry <= 1'b0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  idx   <= '0;
                  wsum  <= '0;
                  if (bad) begin
                     // reject without touching the digit datapath
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                     sum   <= '0;
                     cout  <= 1'b0;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     err   <= 1'b0;
                  end
               end
            end
            RUN: begin
               wsum  <= wsum_nx;
               carry <= dc;
               idx   <= idx + 1'b1;
               if (last) begin
                  sum   <= wsum_nx;
                  cout  <= dc;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

module one_digit_BCD_adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] S,
   output logic       C
);

   logic [4:0] t;

   // binary sum above 9 is corrected by adding 6 and dropping bit 4
   assign t = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
   assign C = (t > 5'd9);
   assign S = C ? 4'(t + 5'd6) : t[3:0];

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: decimal reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_bcd_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic        m_busy = 0;
   logic        m_done = 0;
   logic [15:0] m_sum  = 0;
   logic        m_cout = 0;
   logic        m_err  = 0;
   logic [15:0] p_sum  = 0;
   logic        p_cout = 0;
   int          m_cnt  = 0;

   int done_cyc[$];

   always #5 clk = ~clk;

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic int bcd2int(input logic [15:0] x);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic any_bad(input logic [15:0] x);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) if (x[4*i +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   // transaction-level model: decimal add, fixed latency, one idle gap
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_sum = 0; m_cout = 0; m_err = 0;
         m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 0;
            m_done = 1;
            m_sum  = p_sum;
            m_cout = p_cout;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (start) begin
         if (any_bad(a) || any_bad(b)) begin
            m_done = 1; m_err = 1; m_sum = 0; m_cout = 0;
         end else begin
            int tot;
            tot    = bcd2int(a) + bcd2int(b) + int'(cin);
            p_sum  = int2bcd(tot % 10000);
            p_cout = (tot >= 10000);
            m_busy = 1;
            m_err  = 0;
            m_cnt  = 4;
         end
      end
   end

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("sum", sum, m_sum);
      chk("cout", cout, m_cout);
      chk("err", err, m_err);
      chk("busy_done_excl", busy & done, 0);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 12) begin
         tick();
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done want done", name);
      end
   endtask

   task automatic run(input logic [15:0] xa, input logic [15:0] xb,
                      input logic xc, input logic [15:0] es,
                      input logic ec, input logic ee, input int lat,
                      input string name);
      int k;
      start = 1; a = xa; b = xb; cin = xc;
      tick();
      k = cyc;
      start = 0;
      a = 16'(($urandom));
      b = 16'(($urandom));
      cin = 1'b1;
      chk({name, "_busy0"}, busy, !ee);
      wait_done(name);
      chk({name, "_lat"}, cyc - k, lat);
      chk({name, "_sum"}, sum, es);
      chk({name, "_cout"}, cout, ec);
      chk({name, "_err"}, err, ee);
      chk({name, "_model"}, {m_sum, 15'b0, m_cout}, {es, 15'b0, ec});
      tick();
   endtask

   initial begin
      rst_n = 0; start = 0; a = 0; b = 0; cin = 0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout_err", {cout, err}, 0);
      rst_n = 1;
      tick();

      run(16'h1234, 16'h5678, 0, 16'h6912, 0, 0, 4, "t1");
      run(16'h9999, 16'h0001, 0, 16'h0000, 1, 0, 4, "t2");
      run(16'h9999, 16'h9999, 1, 16'h9999, 1, 0, 4, "t3a");
      run(16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 4, "t3b");
      run(16'h0305, 16'h0007, 0, 16'h0312, 0, 0, 4, "t3c");
      run(16'h12A4, 16'h0001, 0, 16'h0000, 0, 1, 0, "t4a");
      run(16'h0005, 16'h0005, 0, 16'h0010, 0, 0, 4, "t4b");

      // reset two cycles into a run
      start = 1; a = 16'h1111; b = 16'h2222; cin = 0;
      tick();
      start = 0;
      tick();
      tick();
      rst_n = 0;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_sum", sum, 0);
      chk("t5_cout_err", {cout, err}, 0);
      tick();
      tick();
      rst_n = 1;
      tick();
      run(16'h4444, 16'h4444, 0, 16'h8888, 0, 0, 4, "t5b");

      // start pulses during RUN and DONE must be ignored
      start = 1; a = 16'h0250; b = 16'h0750; cin = 0;
      tick();
      start = 0; a = 16'h3333; b = 16'h3333;
      tick();
      start = 1;
      tick();
      start = 0;
      wait_done("t6");
      start = 1;
      tick();
      start = 0;
      chk("t6_sum", sum, 16'h1000);
      chk("t6_cout", cout, 0);
      tick();
      tick();
      chk("t6_idle_sum", sum, 16'h1000);

      // start held high: one accept every 6 cycles
      start = 1; a = 16'h0123; b = 16'h0456; cin = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) done_cyc.push_back(cyc);
      end
      start = 0;
      chk("t6_ndone", done_cyc.size(), 3);
      if (done_cyc.size() >= 3) begin
         chk("t6_gap1", done_cyc[1] - done_cyc[0], 6);
         chk("t6_gap2", done_cyc[2] - done_cyc[1], 6);
      end
      chk("t6_hold_sum", sum, 16'h0579);
      repeat (8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
